fetch_pc_gen: RTL

Parametrised fetch-address generator at the head of the front end. It holds the fetch PC and steps it one aligned fetch block at a time. It also arbitrates redirects from the backend and the branch predictor, and issues block requests to TLB/ICache with a valid/ready handshake. The registered fetch PC, slot mask and valid go to the next fetch stage. Stall and clear semantics are those of the existing pipeline segment registers.

---
 rtl/fetch_pc_gen_pkg.sv | 38 +++
 rtl/fetch_pc_gen_if.sv | 17 +
 rtl/fetch_redir_arb.sv | 51 +++++
 rtl/fetch_pc_gen.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/fetch_pc_gen_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pc_gen_pkg
// Shared front-end definitions for the fetch-address generator:
//   - fetch_state_e : BOOT / RUN / PEND sequencing states
//   - DEF_RESET_PC  : default PC loaded on reset
//   - blk_bytes()   : bytes per fetch block for a given fetch width
//   - blk_ofs()     : log2 of the block size (block-offset bit count)
//   - align_addr()  : clears the block-offset bits of an address
// -----------------------------------------------------------------------------
package fetch_pc_gen_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } fetch_state_e;

  localparam logic [31:0]  DEF_RESET_PC    = 32'h1C00_0000;
  localparam int unsigned  DEF_FETCH_WIDTH = 2;
  localparam int unsigned  INSN_BYTES      = 4;

  function automatic int unsigned blk_bytes(input int unsigned fw);
    return INSN_BYTES * fw;
  endfunction

  function automatic int unsigned blk_ofs(input int unsigned fw);
    return $clog2(INSN_BYTES * fw);
  endfunction

  // Addresses are handled as 64-bit here so one helper serves any XLEN <= 64.
  function automatic logic [63:0] align_addr(input logic [63:0] addr,
                                             input int unsigned ofs);
    logic [63:0] keep;
    keep = ~64'd0 << ofs;
    return addr & keep;
  endfunction

endpackage

// File: rtl/fetch_pc_gen_if.sv
// -----------------------------------------------------------------------------
// fetch_pc_gen_if
// Block-request channel from the fetch-address generator to TLB/ICache.
//   req_valid : request present (master -> slave)
//   req_addr  : block-aligned request address (master -> slave)
//   req_ready : slave accepts the request this cycle (slave -> master)
// -----------------------------------------------------------------------------
interface fetch_pc_gen_if #(
  parameter int unsigned XLEN = 32
);
  logic            req_valid;
  logic [XLEN-1:0] req_addr;
  logic            req_ready;

  modport master (output req_valid, output req_addr, input req_ready);
  modport slave  (input req_valid, input req_addr, output req_ready);
endinterface

// File: rtl/fetch_redir_arb.sv
// -----------------------------------------------------------------------------
// fetch_redir_arb
// Combinational redirect arbiter. Picks between a backend redirect, a predictor
// redirect and an already-pending redirect, and reports the winning target and
// whether it originated from the backend (its priority tag).
//   be_valid_i/be_pc_i      : backend redirect request and target
//   bp_valid_i/bp_pc_i      : predictor redirect request and target
//   pend_active_i           : a redirect is currently parked in the pending reg
//   pend_pc_i/pend_be_i     : parked target and its priority tag
//   redir_o                 : some redirect (new or parked) is in effect
//   tgt_pc_o                : winning target, low two bits forced to zero
//   tgt_be_o                : winning target came from the backend
// -----------------------------------------------------------------------------
module fetch_redir_arb #(
  parameter int unsigned XLEN = 32
) (
  input  logic            be_valid_i,
  input  logic [XLEN-1:0] be_pc_i,
  input  logic            bp_valid_i,
  input  logic [XLEN-1:0] bp_pc_i,
  input  logic            pend_active_i,
  input  logic [XLEN-1:0] pend_pc_i,
  input  logic            pend_be_i,
  output logic            redir_o,
  output logic [XLEN-1:0] tgt_pc_o,
  output logic            tgt_be_o
);

  logic [XLEN-1:0] new_pc;
  logic [XLEN-1:0] tgt_raw;
  logic            pend_we;

  assign new_pc = be_valid_i ? be_pc_i : bp_pc_i;

  // A new redirect replaces the parked one when it is of equal or higher
  // priority; only a predictor redirect against a parked backend one loses.
  assign pend_we = be_valid_i | (bp_valid_i & ~(pend_active_i & pend_be_i));

  always_comb begin
    tgt_raw  = new_pc;
    tgt_be_o = be_valid_i;
    if (pend_active_i && !pend_we) begin
      tgt_raw  = pend_pc_i;
      tgt_be_o = pend_be_i;
    end
  end

  assign redir_o  = be_valid_i | bp_valid_i | pend_active_i;
  assign tgt_pc_o = tgt_raw & ~XLEN'(3);

endmodule

// File: rtl/fetch_pc_gen.sv
// -----------------------------------------------------------------------------
// fetch_pc_gen
// Fetch-address generator. Holds the fetch PC, steps it one aligned block per
// accepted request, applies backend/predictor redirects and feeds a stage
// register (pc / slot_mask / valid / clear) to the next fetch stage.
//   clk, rst          : clock, synchronous active-high reset
//   stall_RegInput    : hold output register and fetch PC, block request fire
//   clear_RegInput    : flush output register (valid drops next cycle)
//   be_redir_valid/pc : backend redirect
//   bp_redir_valid/pc : predictor redirect
//   req_if            : block request channel to TLB/ICache (master side)
//   pc, slot_mask     : registered entry PC and valid instruction slots
//   valid, clear      : registered block valid and registered clear
// -----------------------------------------------------------------------------
module fetch_pc_gen
  import fetch_pc_gen_pkg::*;
#(
  parameter int unsigned      XLEN        = 32,
  parameter logic [XLEN-1:0]  RESET_PC    = XLEN'(DEF_RESET_PC),
  parameter int unsigned      FETCH_WIDTH = DEF_FETCH_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall_RegInput,
  input  logic                   clear_RegInput,
  input  logic                   be_redir_valid,
  input  logic [XLEN-1:0]        be_redir_pc,
  input  logic                   bp_redir_valid,
  input  logic [XLEN-1:0]        bp_redir_pc,
  fetch_pc_gen_if.master         req_if,
  output logic [XLEN-1:0]        pc,
  output logic [FETCH_WIDTH-1:0] slot_mask,
  output logic                   valid,
  output logic                   clear
);

  localparam int unsigned BLK_BYTES = blk_bytes(FETCH_WIDTH);
  localparam int unsigned OFS       = blk_ofs(FETCH_WIDTH);
  localparam logic [FETCH_WIDTH-1:0] FULL_MASK = {FETCH_WIDTH{1'b1}};

  fetch_state_e           state_q, state_d;
  logic [XLEN-1:0]        fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]        pend_pc_q, pend_pc_d;
  logic                   pend_be_q, pend_be_d;
  logic [XLEN-1:0]        pc_q, pc_d;
  logic [FETCH_WIDTH-1:0] slot_mask_q, slot_mask_d;
  logic                   valid_q, valid_d;
  logic                   clear_q, clear_d;

  logic                   req_valid_w;
  logic [XLEN-1:0]        req_addr_w;
  logic [XLEN-1:0]        seq_pc;
  logic [XLEN-1:0]        slot_sel;
  logic                   fire;
  logic                   redir_any;
  logic [XLEN-1:0]        tgt_pc;
  logic                   tgt_be;

  // Request channel is a pure function of state: in PEND fetch_pc_q still
  // points at the unaccepted block, so the address stays stable by itself.
  assign req_valid_w      = (state_q != ST_BOOT);
  assign req_addr_w       = XLEN'(align_addr(64'(fetch_pc_q), OFS));
  assign req_if.req_valid = req_valid_w;
  assign req_if.req_addr  = req_addr_w;

  assign fire     = req_valid_w & req_if.req_ready & ~stall_RegInput;
  assign seq_pc   = req_addr_w + XLEN'(BLK_BYTES);
  assign slot_sel = (fetch_pc_q >> 2) & XLEN'(FETCH_WIDTH - 1);

  fetch_redir_arb #(.XLEN(XLEN)) u_redir_arb (
    .be_valid_i    (be_redir_valid),
    .be_pc_i       (be_redir_pc),
    .bp_valid_i    (bp_redir_valid),
    .bp_pc_i       (bp_redir_pc),
    .pend_active_i (state_q == ST_PEND),
    .pend_pc_i     (pend_pc_q),
    .pend_be_i     (pend_be_q),
    .redir_o       (redir_any),
    .tgt_pc_o      (tgt_pc),
    .tgt_be_o      (tgt_be)
  );

  // PC sequencing
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    pend_pc_d  = pend_pc_q;
    pend_be_d  = pend_be_q;
    unique case (state_q)
      ST_BOOT: begin
        // No request is outstanding yet, so a redirect can be applied directly.
        state_d = ST_RUN;
        if (redir_any) begin
          fetch_pc_d = tgt_pc;
        end
      end
      ST_RUN, ST_PEND: begin
        if (fire) begin
          state_d    = ST_RUN;
          pend_be_d  = 1'b0;
          fetch_pc_d = redir_any ? tgt_pc : seq_pc;
        end else if (redir_any) begin
          state_d   = ST_PEND;
          pend_pc_d = tgt_pc;
          pend_be_d = tgt_be;
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

  // Output stage register: clear beats stall; a block fired alongside any
  // redirect (new or parked) is stale and is loaded as invalid.
  always_comb begin
    pc_d        = pc_q;
    slot_mask_d = slot_mask_q;
    valid_d     = valid_q;
    clear_d     = clear_q;
    if (clear_RegInput) begin
      clear_d = 1'b1;
      valid_d = 1'b0;
    end else if (!stall_RegInput) begin
      clear_d = 1'b0;
      valid_d = fire & ~redir_any;
      if (fire) begin
        pc_d        = fetch_pc_q;
        slot_mask_d = FULL_MASK << slot_sel;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_BOOT;
      fetch_pc_q  <= RESET_PC;
      pend_pc_q   <= RESET_PC;
      pend_be_q   <= 1'b0;
      pc_q        <= RESET_PC;
      slot_mask_q <= FULL_MASK;
      valid_q     <= 1'b0;
      clear_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      pend_pc_q   <= pend_pc_d;
      pend_be_q   <= pend_be_d;
      pc_q        <= pc_d;
      slot_mask_q <= slot_mask_d;
      valid_q     <= valid_d;
      clear_q     <= clear_d;
    end
  end

  assign pc        = pc_q;
  assign slot_mask = slot_mask_q;
  assign valid     = valid_q;
  assign clear     = clear_q;

endmodule
